// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage core: holds or flushes stages when forwarding cannot supply an operand.
// Latency: outputs are combinational from state and current inputs; state, counters and timeout flag are registered.
// Backpressure: a memory wait freezes PC..EX/MEM and bubbles WB; a load-use match holds PC/IF and bubbles EX for one cycle.
//
// Ports:
//   clk, rst                           rising-edge clock, synchronous active-high reset
//   MemRead_EXE, Rt_EXE                load in EXE and its destination register
//   Rs_ID, Rt_ID, UsesRt_ID            source registers of the ID instruction
//   BranchTaken_EXE                    branch/jump in EXE resolved taken
//   MemReq_MEM, MemReady_MEM           data-memory handshake of the MEM stage
//   PCWrite .. MEMWB_Flush             per-stage write enables and flushes
//   stall_cycles                       saturating count of cycles with PCWrite=0
//   mem_timeout                        sticky: a memory wait reached MAX_MEM_WAIT cycles
//   state                              0=RUN 1=LOAD_STALL 2=MEM_WAIT
module hazard_stall_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_EXE,
  input  logic [4:0]       Rt_EXE,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRt_ID,
  input  logic             BranchTaken_EXE,
  input  logic             MemReq_MEM,
  input  logic             MemReady_MEM,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic memwait;
  logic load_use;

  assign memwait  = MemReq_MEM & ~MemReady_MEM;
  // Register $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = MemRead_EXE & (Rt_EXE != 5'd0) &
                    ((Rt_EXE == Rs_ID) | (UsesRt_ID & (Rt_EXE == Rt_ID)));

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_Write = 1'b1;
    MEMWB_Flush = 1'b0;
    state_d     = RUN;
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;

    if (!rst) begin
      if (memwait) begin
        // Freeze everything upstream of MEM and feed bubbles into WB until memory answers.
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Write = 1'b0;
        MEMWB_Flush = 1'b1;
        state_d     = MEM_WAIT;
        wait_cnt_d  = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_d == WAIT_MAX) begin
          timeout_d = 1'b1;
        end
      end else if (BranchTaken_EXE) begin
        // Wrong-path instructions in IF/ID and ID/EX are discarded; a pending load-use is moot.
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (load_use && state_q != LOAD_STALL) begin
        // One bubble is enough: after it the loaded value is forwarded from MEM/WB.
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
        state_d    = LOAD_STALL;
      end

      if (!PCWrite && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign mem_timeout  = timeout_q;
  assign state        = state_q;

endmodule
